time_of_day_counter: RTL and testbench
======================================

Name: time_of_day_counter

Overview:
Consumes the divided clock produced by the team's clock-divider stage and turns it into a BCD hours/minutes/seconds time-of-day count for the display path. The divided clock is treated as an asynchronous level. It is synchronised and edge-detected in the system clock domain, prescaled to one-second events, and cascaded through seconds/minutes/hours counters. The block also provides run/stop control, a time-load handshake and carry pulses.

Parameters:
TICKS_PER_SEC, 28'd1, rising edges of tick_in per one-second increment; legal range 1..2^28-1.
SYNC_STAGES, 2, flops in the tick_in synchroniser; minimum 2.

Ports:
clock_in  input  1  system clock; all state on its rising edge.
reset  input  1  asynchronous, active-high reset.
tick_in  input  1  divided clock from the upstream divider; asynchronous level.
start  input  1  one-cycle request: STOP->RUN.
stop  input  1  one-cycle request: RUN->STOP.
set_valid  input  1  load request; held until accepted.
set_ready  output  1  high only in STOP; load accepted on set_valid&&set_ready.
set_hours  input  8  BCD load value for hours, 00-23.
set_minutes  input  8  BCD load value for minutes, 00-59.
set_seconds  input  8  BCD load value for seconds, 00-59.
set_error  output  1  one-cycle pulse: an accepted load was out of range.
running  output  1  1 in RUN.
hours  output  8  BCD hours.
minutes  output  8  BCD minutes.
seconds  output  8  BCD seconds.
sec_pulse  output  1  one-cycle pulse on each seconds update.
min_pulse  output  1  one-cycle pulse when seconds wrap 59->00.
hour_pulse  output  1  one-cycle pulse when minutes wrap 59->00.
day_pulse  output  1  one-cycle pulse on 23:59:59->00:00:00.

Behaviour:
- Reset (asynchronous):
  - Outputs: all outputs are 0, so the time is 00:00:00 and running=0. set_ready goes to 1 immediately once reset deasserts, because the FSM is in STOP.
  - Internal state: FSM=STOP; synchroniser flops, edge-detect history and prescaler are all 0.
  - Reset mid-operation: aborts everything immediately, including a pending load and any in-flight tick.
- Synchroniser and edge detect:
  - tick_in passes through SYNC_STAGES flops.
  - tick_evt = sync_out & ~sync_prev, giving a 1-cycle pulse per rising edge.
  - tick_in high at reset release produces one tick_evt.
  - Latency: if tick_in is first sampled high at edge k, tick_evt is high in the cycle after edge k+SYNC_STAGES-1, and the counters update at edge k+SYNC_STAGES.
- FSM:
  - States: STOP, RUN.
  - STOP->RUN on start; RUN->STOP on stop.
  - start and stop in the same cycle: stop wins, and the FSM ends in STOP.
  - Entering RUN clears the prescaler.
- Prescaler:
  - Counts tick_evt only in RUN, 0..TICKS_PER_SEC-1.
  - On tick_evt at TICKS_PER_SEC-1 it wraps to 0 and issues a second increment.
  - With TICKS_PER_SEC=1, every tick_evt is a second increment.
  - In STOP, tick_evt is ignored and the prescaler holds.
- Counters (BCD, per-digit arithmetic, no binary intermediate):
  - Seconds: 00..59. Low digit 9 wraps to 0 and carries into the high digit; 59->00 asserts min_pulse and increments minutes.
  - Minutes: 00..59, same rule; 59->00 asserts hour_pulse and increments hours.
  - Hours: 00..23. 09->10 and 19->20 carry normally; 23->00 asserts day_pulse.
  - Pulse timing: sec/min/hour/day pulses are registered, high for exactly the cycle in which the new time value is visible on the outputs.
  - Cascade: all cascaded carries happen in the same clock edge.
- Load:
  - Accepted when set_valid&&set_ready, which only occurs in STOP.
  - Validation: every nibble must be ≤9, hours ≤0x23, minutes ≤0x59, seconds ≤0x59.
  - Valid load: the time registers take the values at the next edge and the prescaler is cleared.
  - Invalid load: the time is unchanged and set_error pulses for one cycle at the next edge. The request is still consumed, so no retry occurs.
  - A load never generates sec/min/hour/day pulses.
  - start and an accepted load in the same cycle: the load is applied and the FSM moves to RUN with the prescaler cleared.

Test Plan:
- Reset then 10 tick_in edges while in STOP -> time stays 00:00:00, no pulses, set_ready=1, running=0.
- Load 23:59:58, start, 2 tick_in edges -> 23:59:59, then 00:00:00. sec/min/hour/day_pulse all high together on the wrap, each for 1 cycle.
- Load hours=8'h24 (then, separately, minutes=8'h5A) -> set_error 1-cycle pulse each time; time unchanged.
- TICKS_PER_SEC=4, run from 00:00:09, 8 edges -> 00:00:11. seconds changes exactly at edges 4 and 8, and 09->10 carries correctly.
- tick_in held high for 100 cycles -> one increment only. Latency measured = SYNC_STAGES edges from the first high sample.
- start+stop in the same cycle -> STOP. Assert reset mid-RUN at 00:12:34 -> immediately 00:00:00, running=0, all pulses 0.

Source files
------------

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter driven by an asynchronous divided clock.
// The tick is synchronised, edge-detected and prescaled, then cascaded through seconds, minutes and hours.
module time_of_day_counter #(
  parameter logic [27:0] TICKS_PER_SEC = 28'd1,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_seconds,
  output logic       set_error,
  output logic       running,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse
);

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   tick_evt;

  logic [0:0]  state_q, state_d;
  logic [27:0] presc_q, presc_d;
  logic [7:0]  hours_q, hours_d;
  logic [7:0]  minutes_q, minutes_d;
  logic [7:0]  seconds_q, seconds_d;
  logic        sec_pulse_q, sec_pulse_d;
  logic        min_pulse_q, min_pulse_d;
  logic        hour_pulse_q, hour_pulse_d;
  logic        day_pulse_q, day_pulse_d;
  logic        set_error_q, set_error_d;

  logic load_fire, load_ok, sec_inc;
  logic sec_wrap, min_wrap, hour_wrap;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_evt = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Loads are only offered while stopped, and never while reset is held.
  assign set_ready = (state_q == ST_STOP) & ~reset;
  assign load_fire = set_valid & set_ready;
  assign load_ok   = bcd_ok(set_hours, 8'h23) & bcd_ok(set_minutes, 8'h59) &
                     bcd_ok(set_seconds, 8'h59);

  assign sec_inc   = (state_q == ST_RUN) & tick_evt & (presc_q == TICKS_PER_SEC - 28'd1);
  assign sec_wrap  = (seconds_q == 8'h59);
  assign min_wrap  = (minutes_q == 8'h59);
  assign hour_wrap = (hours_q == 8'h23);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    sec_pulse_d  = 1'b0;
    min_pulse_d  = 1'b0;
    hour_pulse_d = 1'b0;
    day_pulse_d  = 1'b0;
    set_error_d  = 1'b0;

    if ((state_q == ST_RUN) && tick_evt) presc_d = sec_inc ? 28'd0 : presc_q + 28'd1;

    if (sec_inc) begin
      sec_pulse_d = 1'b1;
      seconds_d   = sec_wrap ? 8'h00 : bcd_inc(seconds_q);
      if (sec_wrap) begin
        min_pulse_d = 1'b1;
        minutes_d   = min_wrap ? 8'h00 : bcd_inc(minutes_q);
        if (min_wrap) begin
          hour_pulse_d = 1'b1;
          hours_d      = hour_wrap ? 8'h00 : bcd_inc(hours_q);
          day_pulse_d  = hour_wrap;
        end
      end
    end

    // An out-of-range load is still consumed; it just flags an error.
    if (load_fire) begin
      if (load_ok) begin
        hours_d   = set_hours;
        minutes_d = set_minutes;
        seconds_d = set_seconds;
        presc_d   = 28'd0;
      end else begin
        set_error_d = 1'b1;
      end
    end

    if (stop) begin
      state_d = ST_STOP;
    end else if (start && (state_q == ST_STOP)) begin
      state_d = ST_RUN;
      presc_d = 28'd0;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_STOP;
      presc_q      <= 28'd0;
      hours_q      <= 8'h00;
      minutes_q    <= 8'h00;
      seconds_q    <= 8'h00;
      sec_pulse_q  <= 1'b0;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
      set_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      sec_pulse_q  <= sec_pulse_d;
      min_pulse_q  <= min_pulse_d;
      hour_pulse_q <= hour_pulse_d;
      day_pulse_q  <= day_pulse_d;
      set_error_q  <= set_error_d;
    end
  end

  assign running    = (state_q == ST_RUN);
  assign hours      = hours_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign sec_pulse  = sec_pulse_q;
  assign min_pulse  = min_pulse_q;
  assign hour_pulse = hour_pulse_q;
  assign day_pulse  = day_pulse_q;
  assign set_error  = set_error_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: one instance at TICKS_PER_SEC=1 and one at 4, sharing all inputs.
module tb_time_of_day_counter;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, start, stop, set_valid;
  logic [7:0] set_h, set_m, set_s;

  logic       ready1, err1, running1, sec_p1, min_p1, hour_p1, day_p1;
  logic [7:0] hours1, minutes1, seconds1;
  logic       ready4, err4, running4, sec_p4, min_p4, hour_p4, day_p4;
  logic [7:0] hours4, minutes4, seconds4;

  time_of_day_counter #(.TICKS_PER_SEC(28'd1), .SYNC_STAGES(SYNC)) dut1 (
    .clock_in(clk), .reset(rst), .tick_in(tick), .start(start), .stop(stop),
    .set_valid(set_valid), .set_ready(ready1), .set_hours(set_h), .set_minutes(set_m),
    .set_seconds(set_s), .set_error(err1), .running(running1), .hours(hours1),
    .minutes(minutes1), .seconds(seconds1), .sec_pulse(sec_p1), .min_pulse(min_p1),
    .hour_pulse(hour_p1), .day_pulse(day_p1)
  );

  time_of_day_counter #(.TICKS_PER_SEC(28'd4), .SYNC_STAGES(SYNC)) dut4 (
    .clock_in(clk), .reset(rst), .tick_in(tick), .start(start), .stop(stop),
    .set_valid(set_valid), .set_ready(ready4), .set_hours(set_h), .set_minutes(set_m),
    .set_seconds(set_s), .set_error(err4), .running(running4), .hours(hours4),
    .minutes(minutes4), .seconds(seconds4), .sec_pulse(sec_p4), .min_pulse(min_p4),
    .hour_pulse(hour_p4), .day_pulse(day_p4)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp_e;
  int m_h, m_m, m_s;

  typedef struct {
    logic [7:0] h, m, s;
    logic       err;
    logic [7:0] eh, em, es;
  } load_vec_t;
  load_vec_t vecs[8];

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int from_bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference time kept in binary; expected BCD time and pulses pushed per increment.
  task automatic model_tick();
    logic mp, hp, dp;
    mp = 1'b0; hp = 1'b0; dp = 1'b0;
    m_s++;
    if (m_s == 60) begin
      m_s = 0; mp = 1'b1; m_m++;
      if (m_m == 60) begin
        m_m = 0; hp = 1'b1; m_h++;
        if (m_h == 24) begin m_h = 0; dp = 1'b1; end
      end
    end
    exp_q.push_back({to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), mp, hp, dp});
  endtask

  // Scoreboard: every seconds update of dut1 must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (sec_p1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sec_pulse_unexpected: got time %0h:%0h:%0h expected no update",
                   hours1, minutes1, seconds1);
        end else begin
          exp_e = exp_q.pop_front();
          check("time_on_sec_pulse",
                32'({hours1, minutes1, seconds1, min_p1, hour_p1, day_p1}), 32'(exp_e));
        end
      end else if (min_p1 | hour_p1 | day_p1) begin
        checks++; errors++;
        $display("FAIL stray_pulse: got min/hour/day %b%b%b expected 000",
                 min_p1, hour_p1, day_p1);
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; set_valid = 1'b0;
    set_h = 8'h00; set_m = 8'h00; set_s = 8'h00;
    exp_q.delete();
    m_h = 0; m_m = 0; m_s = 0;
    repeat (2) @(negedge clk);
    check("outputs_in_reset",
          32'({hours1, minutes1, seconds1, running1, ready1, err1, sec_p1, min_p1, hour_p1, day_p1}),
          32'd0);
    rst = 1'b0;
    #1;
    check("set_ready_after_reset", 32'(ready1), 32'd1);
  endtask

  task automatic do_tick(input bit expect_inc);
    if (expect_inc) model_tick();
    @(negedge clk) tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    int n;
    @(negedge clk);
    set_valid = 1'b1; set_h = h; set_m = m; set_s = s;
    n = 0;
    while (!ready1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL load_handshake: got set_ready 0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{h: 8'h12, m: 8'h34, s: 8'h56, err: 1'b0, eh: 8'h12, em: 8'h34, es: 8'h56};
    vecs[1] = '{h: 8'h24, m: 8'h00, s: 8'h00, err: 1'b1, eh: 8'h12, em: 8'h34, es: 8'h56};
    vecs[2] = '{h: 8'h00, m: 8'h5A, s: 8'h00, err: 1'b1, eh: 8'h12, em: 8'h34, es: 8'h56};
    vecs[3] = '{h: 8'h1A, m: 8'h00, s: 8'h00, err: 1'b1, eh: 8'h12, em: 8'h34, es: 8'h56};
    vecs[4] = '{h: 8'h00, m: 8'h00, s: 8'h60, err: 1'b1, eh: 8'h12, em: 8'h34, es: 8'h56};
    vecs[5] = '{h: 8'h00, m: 8'h00, s: 8'h00, err: 1'b0, eh: 8'h00, em: 8'h00, es: 8'h00};
    vecs[6] = '{h: 8'h09, m: 8'h59, s: 8'h59, err: 1'b0, eh: 8'h09, em: 8'h59, es: 8'h59};
    vecs[7] = '{h: 8'h23, m: 8'h59, s: 8'h58, err: 1'b0, eh: 8'h23, em: 8'h59, es: 8'h58};

    do_reset();

    // Ticks while stopped are ignored
    for (int i = 0; i < 10; i++) do_tick(1'b0);
    check("stop_time_held", 32'({hours1, minutes1, seconds1}), 32'd0);
    check("stop_ready_running", 32'({ready1, running1}), 32'b10);

    // Load table
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("load%0d_error", i), 32'(err1), 32'(vecs[i].err));
      check($sformatf("load%0d_time", i), 32'({hours1, minutes1, seconds1}),
            32'({vecs[i].eh, vecs[i].em, vecs[i].es}));
      @(negedge clk);
      check($sformatf("load%0d_error_clear", i), 32'(err1), 32'd0);
    end
    m_h = 23; m_m = 59; m_s = 58;

    // Day wrap from 23:59:58
    do_start();
    check("running_after_start", 32'({running1, ready1}), 32'b10);
    do_tick(1'b1);
    do_tick(1'b1);
    check("day_wrap_time", 32'({hours1, minutes1, seconds1}), 32'd0);

    // Held tick: one increment, latency in edges from first high sample
    begin
      int cnt;
      model_tick();
      @(negedge clk) tick = 1'b1;
      cnt = 0;
      while (cnt < 20) begin
        @(posedge clk);
        cnt++;
        @(negedge clk);
        if (sec_p1) break;
      end
      check("tick_latency_edges", 32'(cnt - 1), 32'(SYNC));
      repeat (100) @(negedge clk);
      tick = 1'b0;
      repeat (4) @(negedge clk);
      check("held_tick_single_inc", 32'({hours1, minutes1, seconds1}), 32'h000001);
    end

    // start and stop together: stop wins from RUN and from STOP
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("start_stop_from_run", 32'(running1), 32'd0);
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("start_stop_from_stop", 32'(running1), 32'd0);

    // Prescaler of 4 on dut4, running from 00:00:09
    do_reset();
    do_load(8'h00, 8'h00, 8'h09);
    m_h = 0; m_m = 0; m_s = 9;
    do_start();
    for (int i = 1; i <= 8; i++) begin
      do_tick(1'b1);
      check($sformatf("presc4_edge%0d", i), 32'({hours4, minutes4, seconds4}),
            32'({8'h00, 8'h00, to_bcd(9 + i / 4)}));
    end

    // Load accepted together with start
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    @(negedge clk);
    set_valid = 1'b1; set_h = 8'h01; set_m = 8'h02; set_s = 8'h03; start = 1'b1;
    @(negedge clk);
    set_valid = 1'b0; start = 1'b0;
    check("load_with_start", 32'({running1, err1, hours1, minutes1, seconds1}),
          32'({1'b1, 1'b0, 24'h010203}));
    m_h = 1; m_m = 2; m_s = 3;
    do_tick(1'b1);

    // Reset mid-run at 00:12:34 with a tick in flight
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    do_load(8'h00, 8'h12, 8'h34);
    do_start();
    check("pre_reset_time", 32'({running1, hours1, minutes1, seconds1}), 32'({1'b1, 24'h001234}));
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs",
          32'({hours1, minutes1, seconds1, running1, sec_p1, min_p1, hour_p1, day_p1}), 32'd0);
    check("async_reset_dut4", 32'({hours4, minutes4, seconds4, running4}), 32'd0);
    exp_q.delete();
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("after_reset_release", 32'({ready1, running1, hours1, minutes1, seconds1}),
          32'({1'b1, 1'b0, 24'h000000}));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
